// File: rtl/o_serdes_mc.sv
// o_serdes_mc: multi-lane parallel-to-serial output stage with a one-word
// holding buffer, PLL-lock gating and a channel-bond alignment start.
module o_serdes_mc #(
    parameter string       DATA_RATE  = "SDR",
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned NUM_LANES  = 2,
    parameter logic        IDLE_VALUE = 1'b0
) (
    input  logic                                                   CLK_IN,
    input  logic                                                   RST,
    input  logic [NUM_LANES*WIDTH-1:0]                             D,
    input  logic                                                   DATA_VALID,
    output logic                                                   DATA_READY,
    input  logic                                                   OE_IN,
    input  logic                                                   PLL_LOCK,
    input  logic                                                   CHANNEL_BOND_SYNC_IN,
    output logic [NUM_LANES*((DATA_RATE == "DDR") ? 2 : 1)-1:0]    Q,
    output logic                                                   OE_OUT,
    output logic                                                   CHANNEL_BOND_SYNC_OUT,
    output logic                                                   UNDERRUN
);

    localparam int unsigned BPC   = (DATA_RATE == "DDR") ? 2 : 1;
    localparam int unsigned N     = WIDTH / BPC;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned DW    = NUM_LANES * WIDTH;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(N - 1);
    localparam logic [DW-1:0]    IDLE_FILL = {DW{IDLE_VALUE}};

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_SYNC      = 2'd1,
        ST_RUN       = 2'd2
    } state_e;

    state_e                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic                           buf_valid_q, buf_valid_d;
    logic [DW-1:0]                  buf_data_q, buf_data_d;
    logic                           buf_oe_q, buf_oe_d;
    logic [NUM_LANES-1:0][WIDTH-1:0] shift_q, shift_d;
    logic                           oe_q, oe_d;
    logic                           sync_out_q, sync_out_d;
    logic                           underrun_q, underrun_d;
    logic                           load_c;
    logic                           accept_c;

    // State register
    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            state_q <= ST_WAIT_LOCK;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: lock loss wins from any state, sync strobe only honoured in SYNC
    always_comb begin
        state_d = state_q;
        if (!PLL_LOCK) begin
            state_d = ST_WAIT_LOCK;
        end else begin
            case (state_q)
                ST_WAIT_LOCK: state_d = ST_SYNC;
                ST_SYNC:      if (CHANNEL_BOND_SYNC_IN) state_d = ST_RUN;
                ST_RUN:       state_d = ST_RUN;
                default:      state_d = ST_WAIT_LOCK;
            endcase
        end
    end

    // Output/datapath: handshake, buffer, shifters, slot counter and flags
    always_comb begin
        load_c      = PLL_LOCK &&
                      ((state_q == ST_SYNC && CHANNEL_BOND_SYNC_IN) ||
                       (state_q == ST_RUN  && cnt_q == CNT_LAST));
        DATA_READY  = (state_q != ST_WAIT_LOCK) && (!buf_valid_q || load_c);
        accept_c    = DATA_VALID && DATA_READY;

        cnt_d       = cnt_q;
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
        buf_oe_d    = buf_oe_q;
        shift_d     = shift_q;
        oe_d        = oe_q;
        sync_out_d  = 1'b0;
        underrun_d  = underrun_q;

        if (!PLL_LOCK) begin
            // Lock lost: drop buffered and partially shifted data
            cnt_d       = '0;
            buf_valid_d = 1'b0;
            shift_d     = IDLE_FILL;
            oe_d        = 1'b0;
        end else begin
            if (load_c) begin
                shift_d     = buf_valid_q ? buf_data_q : IDLE_FILL;
                oe_d        = buf_valid_q & buf_oe_q;
                cnt_d       = '0;
                sync_out_d  = 1'b1;
                buf_valid_d = 1'b0;
                if (state_q == ST_RUN && !buf_valid_q) begin
                    underrun_d = 1'b1;
                end
            end else if (state_q == ST_RUN) begin
                cnt_d = cnt_q + CNT_W'(1);
                for (int unsigned l = 0; l < NUM_LANES; l++) begin
                    shift_d[l] = {shift_q[l][WIDTH-BPC-1:0], {BPC{IDLE_VALUE}}};
                end
            end
            // A new word may enter the buffer in the same cycle it is emptied
            if (accept_c) begin
                buf_data_d  = D;
                buf_oe_d    = OE_IN;
                buf_valid_d = 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            cnt_q       <= '0;
            buf_valid_q <= 1'b0;
            buf_data_q  <= '0;
            buf_oe_q    <= 1'b0;
            shift_q     <= IDLE_FILL;
            oe_q        <= 1'b0;
            sync_out_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            buf_valid_q <= buf_valid_d;
            buf_data_q  <= buf_data_d;
            buf_oe_q    <= buf_oe_d;
            shift_q     <= shift_d;
            oe_q        <= oe_d;
            sync_out_q  <= sync_out_d;
            underrun_q  <= underrun_d;
        end
    end

    // Serial outputs come straight from the top bits of each shifter, MSB first
    for (genvar gl = 0; gl < NUM_LANES; gl++) begin : g_lane
        for (genvar gb = 0; gb < BPC; gb++) begin : g_bit
            assign Q[gl*BPC+gb] = shift_q[gl][WIDTH-1-gb];
        end
    end

    assign OE_OUT                = oe_q;
    assign CHANNEL_BOND_SYNC_OUT = sync_out_q;
    assign UNDERRUN              = underrun_q;

endmodule

// File: tb/tb_o_serdes_mc.sv
// Self-checking bench for o_serdes_mc: directed scenarios plus random stimulus
// against a queue-based reference model (SDR, 4 bits, 2 lanes), and a short
// directed DDR check on a second instance.
module tb_o_serdes_mc;

    localparam int W = 4;
    localparam int L = 2;
    localparam int N = 4;

    logic       clk;
    logic       rst;
    logic [7:0] d;
    logic       dv, rdy, oe_in, pll, sin;
    logic [1:0] q;
    logic       oe_out, sout, urun;

    logic       rst2;
    logic [5:0] d2;
    logic       dv2, rdy2, oe2, pll2, sin2;
    logic [1:0] q2;
    logic       oe_out2, sout2, urun2;

    int n_tests;
    int n_fail;

    // Reference model state
    int         m_mode;      // 0 waiting for lock, 1 awaiting sync, 2 streaming
    logic       m_bv;
    logic [7:0] m_buf;
    logic       m_boe;
    logic [1:0] m_q[$];      // Q values still to appear, one per cycle
    logic       m_oe, m_pulse, m_ur;

    logic [1:0] last_q;
    logic       last_oe, last_so, last_ur, last_rdy;
    logic       cap_en;
    logic [1:0] cap[$];
    logic       ucap[$];

    o_serdes_mc u_dut (
        .CLK_IN               (clk),
        .RST                  (rst),
        .D                    (d),
        .DATA_VALID           (dv),
        .DATA_READY           (rdy),
        .OE_IN                (oe_in),
        .PLL_LOCK             (pll),
        .CHANNEL_BOND_SYNC_IN (sin),
        .Q                    (q),
        .OE_OUT               (oe_out),
        .CHANNEL_BOND_SYNC_OUT(sout),
        .UNDERRUN             (urun)
    );

    o_serdes_mc #(.DATA_RATE("DDR"), .WIDTH(6), .NUM_LANES(1)) u_ddr (
        .CLK_IN               (clk),
        .RST                  (rst2),
        .D                    (d2),
        .DATA_VALID           (dv2),
        .DATA_READY           (rdy2),
        .OE_IN                (oe2),
        .PLL_LOCK             (pll2),
        .CHANNEL_BOND_SYNC_IN (sin2),
        .Q                    (q2),
        .OE_OUT               (oe_out2),
        .CHANNEL_BOND_SYNC_OUT(sout2),
        .UNDERRUN             (urun2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_bv    = 1'b0;
        m_buf   = '0;
        m_boe   = 1'b0;
        m_q.delete();
        m_oe    = 1'b0;
        m_pulse = 1'b0;
        m_ur    = 1'b0;
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model
    task automatic cycle(input logic lock, input logic sync, input logic valid,
                         input logic [7:0] din, input logic oe, output logic acc);
        logic [1:0] exp_q;
        logic       load, rdy_e;
        logic [7:0] w, t;
        logic [1:0] e;
        @(negedge clk);
        pll = lock; sin = sync; dv = valid; d = din; oe_in = oe;
        #1;
        exp_q = (m_q.size() > 0) ? m_q[0] : 2'b00;
        load  = lock && ((m_mode == 1 && sync) || (m_mode == 2 && m_q.size() == 1));
        rdy_e = (m_mode != 0) && (!m_bv || load);
        chk("q",        32'(q),    32'(exp_q));
        chk("oe_out",   32'(oe_out), 32'(m_oe));
        chk("sync_out", 32'(sout), 32'(m_pulse));
        chk("underrun", 32'(urun), 32'(m_ur));
        chk("ready",    32'(rdy),  32'(rdy_e));
        last_q = q; last_oe = oe_out; last_so = sout; last_ur = urun; last_rdy = rdy;
        if (cap_en) begin
            cap.push_back(q);
            ucap.push_back(urun);
        end
        acc = valid && rdy_e;
        if (!lock) begin
            m_mode  = 0;
            m_q.delete();
            m_bv    = 1'b0;
            m_oe    = 1'b0;
            m_pulse = 1'b0;
        end else begin
            m_pulse = load;
            if (m_mode == 2 && m_q.size() > 0) void'(m_q.pop_front());
            if (load) begin
                w = m_bv ? m_buf : 8'h00;
                for (int k = 0; k < N; k++) begin
                    e = '0;
                    for (int l = 0; l < L; l++) begin
                        t = w >> (l*W + W-1-k);
                        e = e | (2'(t[0]) << l);
                    end
                    m_q.push_back(e);
                end
                m_oe = m_bv & m_boe;
                if (m_mode == 2 && !m_bv) m_ur = 1'b1;
                m_bv = 1'b0;
            end
            if (acc) begin
                m_buf = din; m_boe = oe; m_bv = 1'b1;
            end
            if (m_mode == 0) m_mode = 1;
            else if (m_mode == 1 && sync) m_mode = 2;
        end
    endtask

    // Asynchronous reset pulse in the middle of a cycle
    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_q",        32'(q),    32'(0));
        chk("rst_oe",       32'(oe_out), 32'(0));
        chk("rst_underrun", 32'(urun), 32'(0));
        chk("rst_ready",    32'(rdy),  32'(0));
        chk("rst_sync_out", 32'(sout), 32'(0));
        model_reset();
        pll = 1'b0; sin = 1'b0; dv = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic       a;
        logic [1:0] exp_a[4];
        logic [1:0] exp_c[4];
        logic [7:0] words[3];
        logic [11:0] s0, s1;
        int idx, it, pulses;

        n_tests = 0; n_fail = 0;
        cap_en = 1'b0;
        rst = 1'b1; pll = 1'b0; sin = 1'b0; dv = 1'b0; d = '0; oe_in = 1'b0;
        rst2 = 1'b1; pll2 = 1'b0; sin2 = 1'b0; dv2 = 1'b0; d2 = '0; oe2 = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("init_q",     32'(q),    32'(0));
        chk("init_oe",    32'(oe_out), 32'(0));
        chk("init_ready", 32'(rdy),  32'(0));
        chk("init_ur",    32'(urun), 32'(0));
        rst = 1'b0;

        // Basic word A5 then underrun
        exp_a = '{2'b10, 2'b01, 2'b10, 2'b01};
        cycle(1, 0, 0, 8'h00, 0, a);
        cycle(1, 0, 1, 8'hA5, 1, a);
        chk("a5_accept", 32'(a), 32'(1));
        cycle(1, 1, 0, 8'h00, 0, a);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 0, 8'h00, 0, a);
            chk("a5_bits", 32'(last_q), 32'(exp_a[i]));
            chk("a5_oe", 32'(last_oe), 32'(1));
            pulses += int'(last_so);
        end
        chk("a5_pulses", 32'(pulses), 32'(1));
        cycle(1, 0, 0, 8'h00, 0, a);
        chk("ur_q",  32'(last_q),  32'(0));
        chk("ur_oe", 32'(last_oe), 32'(0));
        chk("ur_flag", 32'(last_ur), 32'(1));
        do_reset();

        // Back-to-back stream 3C, F0, 0F
        words = '{8'h3C, 8'hF0, 8'h0F};
        idx = 0; it = 0;
        cycle(1, 0, 0, 8'h00, 0, a);
        while (idx < 3 && it < 20) begin
            if (it == 1) cap_en = 1'b1;
            cycle(1, it == 1, 1, words[idx], 1, a);
            if (a) idx++;
            it++;
        end
        chk("b2b_accepted", 32'(idx), 32'(3));
        repeat (14) cycle(1, 0, 0, 8'h00, 0, a);
        cap_en = 1'b0;
        s0 = '0; s1 = '0;
        for (int i = 1; i <= 12; i++) begin
            s0 = {s0[10:0], cap[i][0]};
            s1 = {s1[10:0], cap[i][1]};
        end
        chk("b2b_lane0", 32'(s0), 32'(12'hC0F));
        chk("b2b_lane1", 32'(s1), 32'(12'h3F0));
        chk("b2b_no_ur", 32'(ucap[12]), 32'(0));
        chk("b2b_ur_after", 32'(ucap[13]), 32'(1));
        do_reset();

        // Lock loss mid-word, then relock and resync
        cycle(1, 0, 0, 8'h00, 0, a);
        cycle(1, 0, 1, 8'h96, 1, a);
        cycle(1, 1, 0, 8'h00, 0, a);
        cycle(1, 0, 0, 8'h00, 0, a);
        cycle(1, 0, 0, 8'h00, 0, a);
        cycle(0, 0, 0, 8'h00, 0, a);
        cycle(0, 0, 1, 8'h11, 1, a);
        chk("ll_q",     32'(last_q),   32'(0));
        chk("ll_ready", 32'(last_rdy), 32'(0));
        chk("ll_oe",    32'(last_oe),  32'(0));
        exp_c = '{2'b01, 2'b10, 2'b01, 2'b10};
        cycle(1, 0, 0, 8'h00, 0, a);
        cycle(1, 0, 1, 8'h5A, 1, a);
        cycle(1, 1, 0, 8'h00, 0, a);
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 0, 8'h00, 0, a);
            chk("relock_bits", 32'(last_q), 32'(exp_c[i]));
        end
        do_reset();

        // Randomised traffic with occasional lock drops and resets
        for (int i = 0; i < 800; i++) begin
            if (i % 250 == 249) do_reset();
            cycle($urandom_range(0, 39) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom), a);
        end

        // DDR instance: 6-bit word 110010 on one lane
        @(negedge clk); rst2 = 1'b0;
        @(negedge clk); pll2 = 1'b1;
        @(negedge clk); dv2 = 1'b1; d2 = 6'b110010; oe2 = 1'b1;
        #1 chk("ddr_ready_fill", 32'(rdy2), 32'(1));
        @(negedge clk); dv2 = 1'b0; sin2 = 1'b1;
        #1 chk("ddr_ready_load", 32'(rdy2), 32'(1));
        @(negedge clk); sin2 = 1'b0;
        #1;
        chk("ddr_pair0", 32'(q2), 32'(2'b11));
        chk("ddr_oe", 32'(oe_out2), 32'(1));
        chk("ddr_sync_out", 32'(sout2), 32'(1));
        @(negedge clk);
        #1 chk("ddr_pair1", 32'(q2), 32'(2'b00));
        @(negedge clk);
        #1 chk("ddr_pair2", 32'(q2), 32'(2'b01));
        @(negedge clk);
        #1;
        chk("ddr_idle_q", 32'(q2), 32'(2'b00));
        chk("ddr_idle_oe", 32'(oe_out2), 32'(0));
        chk("ddr_underrun", 32'(urun2), 32'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
